// File: rtl/iir_deemph.sv
// First-order fixed-point de-emphasis IIR stage between two FWFT FIFOs, using one
// multiplier shared over three MAC cycles. Define IIR_DEEMPH_SATURATE_EN to saturate the result instead of wrapping it.
module iir_deemph #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS = 10,
    parameter logic signed [DATA_WIDTH-1:0] X0_COEFF = DATA_WIDTH'(178),
    parameter logic signed [DATA_WIDTH-1:0] X1_COEFF = DATA_WIDTH'(178),
    parameter logic signed [DATA_WIDTH-1:0] Y1_COEFF = DATA_WIDTH'(-667)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = DATA_WIDTH + 2;
    localparam logic signed [PW-1:0] RND = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};
`ifdef IIR_DEEMPH_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_READ  = 3'd0,
        S_MAC0  = 3'd1,
        S_MAC1  = 3'd2,
        S_MAC2  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                  state_r, state_next_s;
    logic signed [DATA_WIDTH-1:0] x_cur_r, x_prev_r, y_prev_r;
    logic signed [AW-1:0]    acc_r, acc_next_s;
    logic signed [DATA_WIDTH-1:0] mul_coeff_s, mul_data_s;
    logic signed [PW-1:0]    coeff_ext_s, data_ext_s, product_s;
    logic [DATA_WIDTH-1:0]   result_s;

    // Dequantize: bias negative products so the arithmetic shift truncates toward zero.
    function automatic logic signed [AW-1:0] deq(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] adj;
        logic signed [PW-1:0] shifted;
        adj = p[PW-1] ? (p + RND) : p;
        shifted = adj >>> BITS;
        return AW'(shifted);
    endfunction

    // Reduce the accumulator to the output width; the feedback path reuses this value.
    function automatic logic [DATA_WIDTH-1:0] reduce(input logic signed [AW-1:0] a);
`ifdef IIR_DEEMPH_SATURATE_EN
        if (a > SAT_MAX) begin
            return DATA_WIDTH'(SAT_MAX);
        end else if (a < SAT_MIN) begin
            return DATA_WIDTH'(SAT_MIN);
        end else begin
            return DATA_WIDTH'(a);
        end
`else
        return DATA_WIDTH'(a);
`endif
    endfunction

    // Shared multiplier operand select, one coefficient/sample pair per MAC state.
    always_comb begin
        mul_coeff_s = X0_COEFF;
        mul_data_s  = x_cur_r;
        case (state_r)
            S_MAC0: begin
                mul_coeff_s = X0_COEFF;
                mul_data_s  = x_cur_r;
            end
            S_MAC1: begin
                mul_coeff_s = X1_COEFF;
                mul_data_s  = x_prev_r;
            end
            S_MAC2: begin
                mul_coeff_s = Y1_COEFF;
                mul_data_s  = y_prev_r;
            end
            default: begin
                mul_coeff_s = X0_COEFF;
                mul_data_s  = x_cur_r;
            end
        endcase
    end

    assign coeff_ext_s = {{DATA_WIDTH{mul_coeff_s[DATA_WIDTH-1]}}, mul_coeff_s};
    assign data_ext_s  = {{DATA_WIDTH{mul_data_s[DATA_WIDTH-1]}}, mul_data_s};
    assign product_s   = coeff_ext_s * data_ext_s;
    assign acc_next_s  = acc_r + deq(product_s);
    assign result_s    = reduce(acc_next_s);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_READ: begin
                if (!in_empty) begin
                    state_next_s = S_MAC0;
                end else begin
                    state_next_s = S_READ;
                end
            end
            S_MAC0:  state_next_s = S_MAC1;
            S_MAC1:  state_next_s = S_MAC2;
            S_MAC2:  state_next_s = S_WRITE;
            S_WRITE: begin
                if (!out_full) begin
                    state_next_s = S_READ;
                end else begin
                    state_next_s = S_WRITE;
                end
            end
            default: state_next_s = S_READ;
        endcase
    end

    // FIFO strobes; suppressed while reset is asserted so nothing moves in the reset cycle.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end else begin
            in_rd_en  = (state_r == S_READ) && !in_empty;
            out_wr_en = (state_r == S_WRITE) && !out_full;
        end
    end

    // Datapath and state registers; history advances only on an accepted write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= S_READ;
            x_cur_r  <= '0;
            x_prev_r <= '0;
            y_prev_r <= '0;
            acc_r    <= '0;
            out_din  <= '0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                S_READ: begin
                    if (in_rd_en) begin
                        x_cur_r <= in_dout;
                        acc_r   <= '0;
                    end
                end
                S_MAC0, S_MAC1: acc_r <= acc_next_s;
                S_MAC2: begin
                    acc_r   <= acc_next_s;
                    out_din <= result_s;
                end
                S_WRITE: begin
                    if (out_wr_en) begin
                        x_prev_r <= x_cur_r;
                        y_prev_r <= out_din;
                    end
                end
                default: acc_r <= '0;
            endcase
        end
    end

endmodule
